// File: rtl/mem_copy_master.sv
// Block-copy DMA initiator on the data-memory port: reads a word, then writes it, one word at a time.
// Define MEMCOPY_CHECKSUM_EN to add a running 32-bit sum of the written words on oChecksum.
module mem_copy_master #(
  parameter int COUNT_W      = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic [31:0]        iSrcAddr,
  input  logic [31:0]        iDstAddr,
  input  logic [COUNT_W-1:0] iWordCount,
  input  logic               iBusGrant,
  input  logic [31:0]        iMemData,
  output logic [31:0]        oAddress,
  output logic [3:0]         oByteEnable,
  output logic [31:0]        oWriteData,
  output logic               oMemRead,
  output logic               oMemWrite,
  output logic               oBusy,
  output logic               oDone,
  output logic [31:0]        oChecksum
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RWAIT,
    WR,
    DONE
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY);

  state_t             state;
  logic [31:0]        srcAddr;
  logic [31:0]        dstAddr;
  logic [31:0]        dataBuf;
  logic [COUNT_W-1:0] remaining;
  logic [2:0]         latCnt;
  logic               busyReg;
  logic               doneReg;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      srcAddr   <= '0;
      dstAddr   <= '0;
      dataBuf   <= '0;
      remaining <= '0;
      latCnt    <= '0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            busyReg <= 1'b1;
            if (iWordCount != '0) begin
              srcAddr   <= iSrcAddr & ~32'h3;
              dstAddr   <= iDstAddr & ~32'h3;
              remaining <= iWordCount;
              state     <= RD;
            end else begin
              doneReg <= 1'b1;
              state   <= DONE;
            end
          end
        end
        RD: begin
          if (iBusGrant) begin
            latCnt <= LAT_INIT;
            state  <= RWAIT;
          end
        end
        RWAIT: begin
          // The counter hits 1 exactly READ_LATENCY cycles after the strobe cycle.
          latCnt <= latCnt - 3'd1;
          if (latCnt == 3'd1) begin
            dataBuf <= iMemData;
            state   <= WR;
          end
        end
        WR: begin
          if (iBusGrant) begin
            srcAddr   <= srcAddr + 32'd4;
            dstAddr   <= dstAddr + 32'd4;
            remaining <= remaining - COUNT_W'(1);
            if (remaining == COUNT_W'(1)) begin
              doneReg <= 1'b1;
              state   <= DONE;
            end else begin
              state <= RD;
            end
          end
        end
        DONE: begin
          busyReg <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busyReg <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Strobes follow the grant in the same cycle; address and data are register-driven.
  assign oMemRead    = (state == RD) && iBusGrant;
  assign oMemWrite   = (state == WR) && iBusGrant;
  assign oByteEnable = (oMemRead || oMemWrite) ? 4'hF : 4'h0;
  assign oAddress    = (state == WR) ? dstAddr : srcAddr;
  assign oWriteData  = dataBuf;
  assign oBusy       = busyReg;
  assign oDone       = doneReg;

`ifdef MEMCOPY_CHECKSUM_EN
  logic [31:0] checksum;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      checksum <= '0;
    end else if ((state == IDLE) && iStart) begin
      checksum <= '0;
    end else if ((state == WR) && iBusGrant) begin
      checksum <= checksum + dataBuf;
    end
  end

  assign oChecksum = checksum;
`else
  assign oChecksum = 32'h0;
`endif

endmodule

// File: tb/tb_mem_copy_master.sv
// Scoreboarded bench for mem_copy_master: two instances (read latency 1 and 3) run the same
// directed and randomized copies against a word-level memory model.
module tb_mem_copy_master;

  localparam int COUNT_W = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  bit instDone [2];

  function automatic void check(input string name, input int inst,
                                input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL L%0d %s: got %h, expected %h", inst, name, act, exp);
    end
  endfunction

  function automatic void flag(input string name, input int inst, input logic [31:0] act);
    compared++;
    mismatched++;
    $display("FAIL L%0d %s: got %h, expected nothing", inst, name, act);
  endfunction

  // Content of never-written memory locations.
  function automatic logic [31:0] initVal(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE0000;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int RL = (gi == 0) ? 1 : 3;

    logic               rstN;
    logic               start;
    logic               grant;
    logic [31:0]        srcA;
    logic [31:0]        dstA;
    logic [COUNT_W-1:0] wc;
    logic [31:0]        memData;
    logic [31:0]        addr;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic               rd;
    logic               wr;
    logic               busy;
    logic               done;
    logic [31:0]        csum;

    mem_copy_master #(.COUNT_W(COUNT_W), .READ_LATENCY(RL)) dut (
      .iCLK       (iCLK),
      .iRST_N     (rstN),
      .iStart     (start),
      .iSrcAddr   (srcA),
      .iDstAddr   (dstA),
      .iWordCount (wc),
      .iBusGrant  (grant),
      .iMemData   (memData),
      .oAddress   (addr),
      .oByteEnable(be),
      .oWriteData (wdata),
      .oMemRead   (rd),
      .oMemWrite  (wr),
      .oBusy      (busy),
      .oDone      (done),
      .oChecksum  (csum)
    );

    logic [31:0] tbMem  [logic [31:0]];
    logic [31:0] refMem [logic [31:0]];
    logic [31:0] expRd [$];
    wr_t         expWr [$];
    logic [31:0] expSum [$];
    int          expDoneCyc [$];
    int          pendCnt = 0;
    logic [31:0] pendAddr = '0;
    int          rdSeen = 0;
    bit          doneSeen = 1'b0;

    function automatic logic [31:0] tbRead(input logic [31:0] a);
      return tbMem.exists(a) ? tbMem[a] : initVal(a);
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    // Memory model and monitor: everything observed on the falling edge.
    initial begin : monitor
      wr_t         w;
      logic [31:0] s;
      int          c;
      forever begin
        @(negedge iCLK);
        if (pendCnt > 0) begin
          pendCnt--;
          memData = (pendCnt == 0) ? tbRead(pendAddr) : $urandom;
        end else begin
          memData = $urandom;
        end
        if (rstN) begin
          check("byteEnable", RL, 32'(be), (rd || wr) ? 32'hF : 32'h0);
          check("rdWrExclusive", RL, 32'(rd && wr), 32'h0);
          check("strobeWithoutGrant", RL, 32'((rd || wr) && !grant), 32'h0);
          if (rd) begin
            rdSeen++;
            pendCnt  = RL;
            pendAddr = addr;
            check("busyOnRead", RL, 32'(busy), 32'h1);
            if (expRd.size() == 0) flag("unexpectedRead", RL, addr);
            else check("readAddr", RL, addr, expRd.pop_front());
          end
          if (wr) begin
            tbMem[addr] = wdata;
            if (expWr.size() == 0) flag("unexpectedWrite", RL, addr);
            else begin
              w = expWr.pop_front();
              check("writeAddr", RL, addr, w.a);
              check("writeData", RL, wdata, w.d);
            end
          end
          if (done) begin
            doneSeen = 1'b1;
            check("busyOnDone", RL, 32'(busy), 32'h1);
            if (expSum.size() == 0) flag("unexpectedDone", RL, 32'(cyc));
            else begin
              s = expSum.pop_front();
              c = expDoneCyc.pop_front();
              check("checksum", RL, csum, s);
              if (c >= 0) check("doneCycle", RL, 32'(cyc), 32'(c));
            end
          end
        end
      end
    end

    task automatic checkAllZero(input string tag);
      check({tag, ".address"}, RL, addr, 32'h0);
      check({tag, ".byteEnable"}, RL, 32'(be), 32'h0);
      check({tag, ".writeData"}, RL, wdata, 32'h0);
      check({tag, ".strobes"}, RL, 32'({rd, wr}), 32'h0);
      check({tag, ".busyDone"}, RL, 32'({busy, done}), 32'h0);
      check({tag, ".checksum"}, RL, csum, 32'h0);
    endtask

    // Pushes the expected transactions, then drives the start pulse (called at posedge+1).
    task automatic issueCopy(input logic [31:0] src, input logic [31:0] dst,
                             input int n, input int mode);
      logic [31:0] s;
      logic [31:0] d;
      logic [31:0] v;
      logic [31:0] sum;
      s   = src & ~32'h3;
      d   = dst & ~32'h3;
      sum = '0;
      for (int i = 0; i < n; i++) begin
        expRd.push_back(s);
        v = refRead(s);
        refMem[d] = v;
        expWr.push_back({d, v});
        sum += v;
        s += 32'd4;
        d += 32'd4;
      end
`ifndef MEMCOPY_CHECKSUM_EN
      sum = '0;
`endif
      expSum.push_back(sum);
      expDoneCyc.push_back((mode == 0) ? cyc + 1 + n * (2 + RL) : -1);
      doneSeen = 1'b0;
      srcA  = src;
      dstA  = dst;
      wc    = n[COUNT_W-1:0];
      start = 1'b1;
      grant = (mode != 1);
    endtask

    // mode 0: grant always; 1: random grant plus stray start pulses; 2: grant pattern 1,0,0,1.
    task automatic doCopy(input logic [31:0] src, input logic [31:0] dst,
                          input int n, input int mode);
      int         budget;
      int         phase;
      logic [3:0] pat;
      pat = 4'b1001;
      @(posedge iCLK);
      #1;
      check("idleBusy", RL, 32'(busy), 32'h0);
      issueCopy(src, dst, n, mode);
      phase  = 0;
      budget = 500;
      while (!doneSeen && budget > 0) begin
        @(posedge iCLK);
        #1;
        if (doneSeen) break;
        budget--;
        start = 1'b0;
        case (mode)
          0: grant = 1'b1;
          1: begin
            grant = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) begin
              start = 1'b1;
              srcA  = $urandom;
              dstA  = $urandom;
              wc    = COUNT_W'($urandom_range(1, 5));
            end
          end
          default: begin
            grant = pat[phase % 4];
            phase++;
          end
        endcase
      end
      start = 1'b0;
      grant = 1'b0;
      if (!doneSeen) flag("doneTimeout", RL, 32'(cyc));
      check("readsLeft", RL, 32'(expRd.size()), 32'h0);
      check("writesLeft", RL, 32'(expWr.size()), 32'h0);
      $display("L%0d copy src=%h dst=%h words=%0d mode=%0d finished at cycle %0d",
               RL, src, dst, n, mode, cyc);
    endtask

    // Reset lands in the read-wait of the second word; a fresh copy must then run cleanly.
    task automatic abortAndRestart();
      int budget;
      @(posedge iCLK);
      #1;
      rdSeen = 0;
      issueCopy(32'h0000_4000, 32'h0000_5000, 3, 0);
      budget = 100;
      while (rdSeen < 2 && budget > 0) begin
        @(posedge iCLK);
        #1;
        start = 1'b0;
        budget--;
      end
      if (rdSeen < 2) flag("abortSetupTimeout", RL, 32'(rdSeen));
      rstN = 1'b0;
      #1;
      checkAllZero("midResetOutputs");
      expRd.delete();
      expWr.delete();
      expSum.delete();
      expDoneCyc.delete();
      pendCnt = 0;
      refMem  = tbMem;
      grant   = 1'b0;
      repeat (2) @(posedge iCLK);
      #1;
      rstN = 1'b1;
      $display("L%0d reset applied during copy, restarting", RL);
      doCopy(32'h0000_4800, 32'h0000_4900, 2, 0);
    endtask

    initial begin : stimulus
      logic [31:0] pre [4];
      pre = '{32'h11, 32'h22, 32'h33, 32'h44};
      rstN = 1'b1; start = 1'b0; grant = 1'b0;
      srcA = '0; dstA = '0; wc = '0; memData = '0;
      #2;
      rstN = 1'b0;
      #1;
      checkAllZero("resetOutputs");
      repeat (3) @(posedge iCLK);
      #1;
      rstN = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tbMem[32'h2000 + 32'(4 * i)]  = pre[i];
        refMem[32'h2000 + 32'(4 * i)] = pre[i];
      end
      doCopy(32'h0000_2000, 32'h0001_0000, 4, 0);
      doCopy(32'h0000_0000, 32'h0000_0000, 0, 0);
      doCopy(32'h0000_2100, 32'h0000_2200, 2, 2);
      doCopy(32'h0000_0003, 32'h0000_0803, 2, 0);
      doCopy(32'hFFFF_FFF8, 32'h0000_6000, 3, 0);
      abortAndRestart();
      for (int k = 0; k < 8; k++) begin
        doCopy(32'h3000 + 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3)),
               32'h3000 + 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3)),
               $urandom_range(0, 8), $urandom_range(0, 2));
      end
      @(posedge iCLK);
      #1;
      check("finalIdleBusy", RL, 32'(busy), 32'h0);
      instDone[gi] = 1'b1;
    end
  end

  initial begin : summary
    while (!(instDone[0] && instDone[1]) && cyc < 50000) @(posedge iCLK);
    if (!(instDone[0] && instDone[1])) begin
      compared++;
      mismatched++;
      $display("FAIL globalTimeout: got cycle %0d, expected both instances finished", cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
